mod_inverse_bin: RTL and testbench

Parametrised modular multiplicative inverse for the ElGamal datapath (decryption, key setup). Uses the binary extended Euclidean algorithm: shift/subtract only, no divider, one step per clock. Generalises the fixed-width mult_inverse in three ways. It adds a status sideband that flags non-invertible or illegal operands, applies backpressure-correct AXI-stream-style handshakes, and bounds latency as a function of WIDTH.

---
 rtl/mod_inv_pkg.sv | 20 ++
 rtl/mod_halve.sv | 18 +
 rtl/mod_inverse_bin.sv | 174 +++++++++++++++++
 tb/tb_mod_inverse_bin.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_inv_pkg.sv
// Shared types and constants for the binary extended-Euclid modular inverse.
package mod_inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_NOT_INV    = 2'd1;
  localparam logic [1:0] ST_BAD_MOD    = 2'd2;
  localparam logic [1:0] ST_BASE_RANGE = 2'd3;

  // RUN cycle count at which the watchdog aborts a stuck operation
  function automatic int unsigned wd_limit(input int unsigned width);
    return 4 * width + 2;
  endfunction

endpackage

// File: rtl/mod_halve.sv
// Modular halving for odd m: (x even ? x : x + m) >> 1, sum kept on WIDTH+1 bits.
module mod_halve #(
  parameter int unsigned WIDTH = 65
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] y_c
);

  logic [WIDTH:0] sum_c;

  always_comb begin
    sum_c = {1'b0, x};
    if (x[0]) sum_c = sum_c + {1'b0, m};
    y_c = WIDTH'(sum_c >> 1);
  end

endmodule

// File: rtl/mod_inverse_bin.sv
// Modular inverse a^-1 mod m by binary extended Euclid, one step per clock, stream handshakes.
// Optional MOD_INV_CYCLE_COUNT_EN adds output_cycles (RUN cycles of the current result).
module mod_inverse_bin
  import mod_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned CNT_W = $clog2(4*WIDTH+4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_base_tdata,
  input  logic             input_base_tvalid,
  output logic             input_base_tready,
  input  logic [WIDTH-1:0] input_modulus_tdata,
  input  logic             input_modulus_tvalid,
  output logic             input_modulus_tready,
  output logic [WIDTH-1:0] output_tdata,
  output logic [1:0]       output_tuser,
  output logic             output_tvalid,
  input  logic             output_tready
`ifdef MOD_INV_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] output_cycles
`endif
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(wd_limit(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] m_q, m_d, r_q, r_d;
  logic [1:0]       st_q, st_d;
  logic             valid_q, valid_d, ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x1_half_c, x2_half_c;
  logic             accept_c;

  mod_halve #(.WIDTH(WIDTH)) u_halve_x1 (.x(x1_q), .m(m_q), .y_c(x1_half_c));
  mod_halve #(.WIDTH(WIDTH)) u_halve_x2 (.x(x2_q), .m(m_q), .y_c(x2_half_c));

  // Operand checks at acceptance, then one reduction step per RUN cycle
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    m_d      = m_q;
    r_d      = r_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    accept_c = (state_q == IDLE) && input_base_tvalid && input_modulus_tvalid;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          m_d   = input_modulus_tdata;
          u_d   = input_base_tdata;
          v_d   = input_modulus_tdata;
          x1_d  = WIDTH'(1);
          x2_d  = '0;
          cnt_d = '0;
          r_d   = '0;
          st_d  = ST_OK;
          if (!input_modulus_tdata[0] || (input_modulus_tdata < WIDTH'(3))) begin
            st_d    = ST_BAD_MOD;
            state_d = DONE;
          end else if (input_base_tdata >= input_modulus_tdata) begin
            st_d    = ST_BASE_RANGE;
            state_d = DONE;
          end else if (input_base_tdata == '0) begin
            st_d    = ST_NOT_INV;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WD_LIMIT) begin
          r_d     = '0;
          st_d    = ST_NOT_INV;
          state_d = DONE;
        end else if (u_q == WIDTH'(1)) begin
          r_d     = x1_q;
          st_d    = ST_OK;
          state_d = DONE;
        end else if (v_q == WIDTH'(1)) begin
          r_d     = x2_q;
          st_d    = ST_OK;
          state_d = DONE;
        end else if ((u_q == '0) || (v_q == '0)) begin
          r_d     = '0;
          st_d    = ST_NOT_INV;
          state_d = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half_c;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half_c;
        end else if (u_q >= v_q) begin
          // Wrapping WIDTH-bit add of m lands back in [0, m)
          u_d  = u_q - v_q;
          x1_d = x1_q - x2_q + ((x1_q >= x2_q) ? '0 : m_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_q - x1_q + ((x2_q >= x1_q) ? '0 : m_q);
        end
      end
      DONE: begin
        if (output_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      st_q    <= ST_OK;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      m_q     <= m_d;
      r_q     <= r_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign input_base_tready    = ready_q;
  assign input_modulus_tready = ready_q;
  assign output_tdata         = r_q;
  assign output_tuser         = st_q;
  assign output_tvalid        = valid_q;

`ifdef MOD_INV_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // Snapshot of RUN length, zero for results decided at acceptance
  always_comb begin
    cycles_d = cycles_q;
    if (accept_c) cycles_d = '0;
    else if ((state_q == RUN) && (state_d == DONE)) cycles_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end

  assign output_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mod_inverse_bin.sv
// Self-checking bench for mod_inverse_bin: vector table, scoreboard queue, handshake corner cases.
module tb_mod_inverse_bin;

  localparam int unsigned W  = 65;
  localparam int unsigned CW = $clog2(4*W+4);
  localparam logic [1:0] S_OK = 2'd0, S_NI = 2'd1, S_BM = 2'd2, S_BR = 2'd3;
  localparam logic [W-1:0] M64 = 65'd18446744073709551337;
  localparam logic [W-1:0] M61 = 65'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] BIG = 65'd10794478246981970827;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] input_base_tdata, input_modulus_tdata, output_tdata;
  logic         input_base_tvalid, input_modulus_tvalid;
  logic         input_base_tready, input_modulus_tready;
  logic [1:0]   output_tuser;
  logic         output_tvalid, output_tready;
`ifdef MOD_INV_CYCLE_COUNT_EN
  logic [CW-1:0] output_cycles;
`endif

  mod_inverse_bin #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .input_base_tdata(input_base_tdata),
    .input_base_tvalid(input_base_tvalid),
    .input_base_tready(input_base_tready),
    .input_modulus_tdata(input_modulus_tdata),
    .input_modulus_tvalid(input_modulus_tvalid),
    .input_modulus_tready(input_modulus_tready),
    .output_tdata(output_tdata),
    .output_tuser(output_tuser),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready)
`ifdef MOD_INV_CYCLE_COUNT_EN
    , .output_cycles(output_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] r;
    logic [1:0]   st;
    int           max_run;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] r;
    logic [1:0]   st;
    int           max_run;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference inverse by classical (division-based) extended Euclid
  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a, input logic [W-1:0] m);
    logic signed [139:0] r0, r1, t0, t1, q, tmp;
    r0 = {75'b0, m};
    r1 = {75'b0, a};
    t0 = '0;
    t1 = 140'sd1;
    for (int i = 0; i < 400 && r1 != '0; i++) begin
      q   = r0 / r1;
      tmp = t0 - q * t1;
      t0  = t1;
      t1  = tmp;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
    end
    if (r0 != 140'sd1) return '0;
    if (t0 < 0) t0 = t0 + {75'b0, m};
    return t0[W-1:0];
  endfunction

  // Scoreboard: latency check on tvalid rise, data check on handshake
  task automatic monitor();
    bit               pv = 1'b0;
    exp_t             e;
    int               run;
    logic [2*W-1:0]   prod;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (output_tvalid && !pv && sb_q.size() != 0) begin
          run = cyc - sb_q[0].acc_cyc;
          chk(run <= sb_q[0].max_run, "run_cycles", W'(run), W'(sb_q[0].max_run));
        end
        if (output_tvalid && output_tready) begin
          chk(sb_q.size() != 0, "unexpected_output", output_tdata, '0);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(output_tdata == e.r, "tdata", output_tdata, e.r);
            chk(output_tuser == e.st, "tuser", W'(output_tuser), W'(e.st));
            if (e.st == S_OK) begin
              prod = ({{W{1'b0}}, e.a} * {{W{1'b0}}, output_tdata}) % {{W{1'b0}}, e.m};
              chk(prod == (2*W)'(1), "a_times_r_mod_m", prod[W-1:0], W'(1));
            end
          end
        end
        pv = output_tvalid;
      end
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] m);
    @(posedge clk); #1;
    input_base_tdata     = a;
    input_modulus_tdata  = m;
    input_base_tvalid    = 1'b1;
    input_modulus_tvalid = 1'b1;
  endtask

  task automatic accept_wait(input logic [W-1:0] a, input logic [W-1:0] m, input logic [W-1:0] r,
                             input logic [1:0] st, input int max_run, input bit push);
    bit   rdy;
    bit   got = 1'b0;
    exp_t e;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      rdy = input_base_tready && input_modulus_tready;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    input_base_tvalid    = 1'b0;
    input_modulus_tvalid = 1'b0;
    chk(got, "accept_timeout", W'(got), W'(1));
    if (got && push) begin
      e = '{a: a, m: m, r: r, st: st, max_run: max_run, acc_cyc: cyc};
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    chk(sb_q.size() == 0, "result_timeout", W'(sb_q.size()), '0);
    sb_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(!output_tvalid, {tag, "_tvalid"}, W'(output_tvalid), '0);
    chk(output_tdata == '0, {tag, "_tdata"}, output_tdata, '0);
    chk(output_tuser == 2'd0, {tag, "_tuser"}, W'(output_tuser), '0);
    chk(input_base_tready && input_modulus_tready, {tag, "_tready"}, W'(input_base_tready), W'(1));
  endtask

  vec_t         vecs[10];
  logic [W-1:0] hold_d;
  logic [1:0]   hold_u;
  bit           saw;

  initial begin
    rst                  = 1'b1;
    input_base_tdata     = '0;
    input_modulus_tdata  = '0;
    input_base_tvalid    = 1'b0;
    input_modulus_tvalid = 1'b0;
    output_tready        = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork monitor(); join_none
    @(negedge clk);
    check_idle_outputs("reset");

    vecs[0] = '{65'd3,  65'd11, 65'd4,  S_OK, 261};
    vecs[1] = '{65'd3,  65'd7,  65'd5,  S_OK, 261};
    vecs[2] = '{65'd1,  M64,    65'd1,  S_OK, 2};
    vecs[3] = '{BIG,    M64,    ref_inv(BIG, M64), S_OK, 261};
    vecs[4] = '{65'd10, 65'd11, 65'd10, S_OK, 261};
    vecs[5] = '{65'd6,  65'd9,  65'd0,  S_NI, 261};
    vecs[6] = '{65'd0,  65'd7,  65'd0,  S_NI, 0};
    vecs[7] = '{65'd5,  65'd8,  65'd0,  S_BM, 0};
    vecs[8] = '{65'd12, 65'd11, 65'd0,  S_BR, 0};
    vecs[9] = '{65'd0,  65'd1,  65'd0,  S_BM, 0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].m);
      accept_wait(vecs[i].a, vecs[i].m, vecs[i].r, vecs[i].st, vecs[i].max_run, 1'b1);
      wait_idle(400);
    end

    // Backpressure: result held, new operands stalled until the output handshake
    @(posedge clk); #1 output_tready = 1'b0;
    drive(65'd3, 65'd11);
    accept_wait(65'd3, 65'd11, 65'd4, S_OK, 261, 1'b1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (output_tvalid) break;
    end
    chk(output_tvalid, "bp_valid", W'(output_tvalid), W'(1));
    hold_d = output_tdata;
    hold_u = output_tuser;
    drive(65'd5, 65'd7);
    repeat (10) begin
      @(negedge clk);
      chk(output_tvalid && output_tdata == hold_d && output_tuser == hold_u, "bp_hold", output_tdata, hold_d);
      chk(!input_base_tready && !input_modulus_tready, "bp_tready_low", W'(input_base_tready), '0);
    end
    @(posedge clk); #1 output_tready = 1'b1;
    accept_wait(65'd5, 65'd7, 65'd3, S_OK, 261, 1'b1);
    wait_idle(400);

    // Reset mid-RUN discards the operation
    drive(65'd5, M61);
    accept_wait(65'd5, M61, '0, S_OK, 261, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    saw = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (output_tvalid) saw = 1'b1;
    end
    chk(!saw, "rst_no_output", W'(saw), '0);
    drive(65'd3, 65'd11);
    accept_wait(65'd3, 65'd11, 65'd4, S_OK, 261, 1'b1);
    wait_idle(400);

    // Base valid alone is never consumed
    @(posedge clk); #1;
    input_base_tdata     = 65'd10;
    input_modulus_tdata  = 65'd11;
    input_base_tvalid    = 1'b1;
    input_modulus_tvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk(input_base_tready && !output_tvalid, "half_valid_idle", W'(output_tvalid), '0);
    end
    @(posedge clk); #1 input_modulus_tvalid = 1'b1;
    accept_wait(65'd10, 65'd11, 65'd10, S_OK, 261, 1'b1);
    wait_idle(400);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (output_tvalid) saw = 1'b1;
    end
    chk(!saw, "single_result", W'(saw), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
